// File: rtl/turn_controller.sv
// Game-flow front end: debounces the four push-buttons, sequences drop/settle/decide,
// owns the player to move and the latched game outcome, and drives the board clear.
module turn_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SETTLE_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_drop,
   input  logic        btn_new_game,
   input  logic [2:0]  A,
   input  logic [1:0]  win,
   input  logic [11:0] col1,
   input  logic [11:0] col2,
   input  logic [11:0] col3,
   input  logic [11:0] col4,
   input  logic [11:0] col5,
   input  logic [11:0] col6,
   input  logic [11:0] col7,
   output logic        left,
   output logic        right,
   output logic        sel_column,
   output logic        change,
   output logic        player_colour,
   output logic [1:0]  status,
   output logic        reject,
   output logic        clear_n
);

   localparam int unsigned DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] ST_PLAYING = 2'b00;
   localparam logic [1:0] ST_WON     = 2'b01;
   localparam logic [1:0] ST_DRAW    = 2'b10;

   localparam int unsigned BTN_LEFT  = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_DROP  = 2;
   localparam int unsigned BTN_NEW   = 3;

   typedef enum logic [2:0] {
      PLAY   = 3'd0,
      SETTLE = 3'd1,
      DECIDE = 3'd2,
      WON    = 3'd3,
      DRAW   = 3'd4,
      CLEAR  = 3'd5
   } state_t;

   logic [3:0] btn_raw;
   logic [3:0] btn_ev;

   assign btn_raw = {btn_new_game, btn_drop, btn_right, btn_left};

   // Per button: 2-flop sync, stability counter, accepted level, registered rising-edge event
   for (genvar i = 0; i < 4; i++) begin : g_btn
      logic           sync_a;
      logic           sync_b;
      logic           level;
      logic           level_d;
      logic           ev_q;
      logic [DCW-1:0] stable_cnt;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            ev_q       <= 1'b0;
            stable_cnt <= '0;
         end else begin
            sync_a  <= btn_raw[i];
            sync_b  <= sync_a;
            level_d <= level;
            ev_q    <= level & ~level_d;
            if (sync_b == level) begin
               stable_cnt <= '0;
            end else if (stable_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
               level      <= sync_b;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_cnt + DCW'(1);
            end
         end
      end

      assign btn_ev[i] = ev_q;
   end

   logic [11:0] cur_col_c;
   logic        col_full_c;
   logic        board_full_c;
   logic        win_valid_c;
   logic        unused_col_bits;

   // Selector value 7 addresses no column and is treated as full
   always_comb begin
      cur_col_c = 12'hC00;
      case (A)
         3'd0:    cur_col_c = col1;
         3'd1:    cur_col_c = col2;
         3'd2:    cur_col_c = col3;
         3'd3:    cur_col_c = col4;
         3'd4:    cur_col_c = col5;
         3'd5:    cur_col_c = col6;
         3'd6:    cur_col_c = col7;
         default: cur_col_c = 12'hC00;
      endcase
   end

   assign col_full_c   = (cur_col_c[11:10] != 2'b00);
   assign board_full_c = (col1[11:10] != 2'b00) && (col2[11:10] != 2'b00) &&
                         (col3[11:10] != 2'b00) && (col4[11:10] != 2'b00) &&
                         (col5[11:10] != 2'b00) && (col6[11:10] != 2'b00) &&
                         (col7[11:10] != 2'b00);
   assign win_valid_c  = win[0] ^ win[1];

   assign unused_col_bits = ^{col1[9:0], col2[9:0], col3[9:0], col4[9:0],
                              col5[9:0], col6[9:0], col7[9:0]};

   state_t         state;
   logic [SCW-1:0] phase_cnt;

   // Turn sequencer; new-game outranks every other event and is ignored only while clearing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= PLAY;
         phase_cnt     <= '0;
         left          <= 1'b0;
         right         <= 1'b0;
         sel_column    <= 1'b0;
         change        <= 1'b0;
         reject        <= 1'b0;
         player_colour <= 1'b0;
         status        <= ST_PLAYING;
         clear_n       <= 1'b0;
      end else begin
         left       <= 1'b0;
         right      <= 1'b0;
         sel_column <= 1'b0;
         change     <= 1'b0;
         reject     <= 1'b0;
         clear_n    <= 1'b1;
         if (btn_ev[BTN_NEW] && (state != CLEAR)) begin
            state         <= CLEAR;
            phase_cnt     <= '0;
            clear_n       <= 1'b0;
            player_colour <= 1'b0;
            status        <= ST_PLAYING;
         end else begin
            case (state)
               PLAY: begin
                  if (btn_ev[BTN_DROP]) begin
                     if (col_full_c) begin
                        reject <= 1'b1;
                     end else begin
                        sel_column <= 1'b1;
                        change     <= 1'b1;
                        phase_cnt  <= '0;
                        state      <= SETTLE;
                     end
                  end else if (btn_ev[BTN_LEFT] ^ btn_ev[BTN_RIGHT]) begin
                     left  <= btn_ev[BTN_LEFT];
                     right <= btn_ev[BTN_RIGHT];
                  end
               end
               SETTLE: begin
                  if (phase_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                     state <= DECIDE;
                  end else begin
                     phase_cnt <= phase_cnt + SCW'(1);
                  end
               end
               DECIDE: begin
                  if (win_valid_c) begin
                     status <= ST_WON;
                     state  <= WON;
                  end else if (board_full_c) begin
                     status <= ST_DRAW;
                     state  <= DRAW;
                  end else begin
                     player_colour <= ~player_colour;
                     state         <= PLAY;
                  end
               end
               WON, DRAW: begin
                  state <= state;
               end
               CLEAR: begin
                  if (phase_cnt == SCW'(1)) begin
                     state <= PLAY;
                  end else begin
                     clear_n   <= 1'b0;
                     phase_cnt <= phase_cnt + SCW'(1);
                  end
               end
               default: state <= PLAY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: owns a model board (column heights), predicts pulse timing
// from button press times, and checks pulses, colour and outcome after each directed step.
module tb_turn_controller;

   localparam int D = 16;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        b_left, b_right, b_drop, b_new;
   logic [2:0]  a;
   logic [1:0]  win_drv;
   logic [11:0] colv [7];
   logic        left, right, sel_column, change, player_colour, reject, clear_n;
   logic [1:0]  status;

   always #5 clk = ~clk;

   turn_controller #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset),
      .btn_left(b_left), .btn_right(b_right), .btn_drop(b_drop), .btn_new_game(b_new),
      .A(a), .win(win_drv),
      .col1(colv[0]), .col2(colv[1]), .col3(colv[2]), .col4(colv[3]),
      .col5(colv[4]), .col6(colv[5]), .col7(colv[6]),
      .left(left), .right(right), .sel_column(sel_column), .change(change),
      .player_colour(player_colour), .status(status), .reject(reject), .clear_n(clear_n)
   );

   // Board model: a column is just a height; cells alternate colours bottom-up
   int heights [7];

   function automatic logic [11:0] mkcol(input int h);
      logic [11:0] c;
      c = '0;
      for (int r = 0; r < 6; r++)
         if (r < h) c[2*r +: 2] = (r % 2 == 1) ? 2'b10 : 2'b01;
      return c;
   endfunction

   always_comb
      for (int i = 0; i < 7; i++) colv[i] = mkcol(heights[i]);

   int edge_n = 0;
   always @(posedge clk) edge_n = edge_n + 1;

   int   q_left[$], q_right[$], q_sel[$], q_chg[$], q_rej[$], q_pc[$], q_clr[$];
   int   pair_bad = 0;
   logic pc_prev = 1'b0;

   // Mid-cycle monitor: logs the edge each pulse followed; acts as the matrix for the board
   always @(negedge clk) begin
      if (left)       q_left.push_back(edge_n);
      if (right)      q_right.push_back(edge_n);
      if (sel_column) q_sel.push_back(edge_n);
      if (change)     q_chg.push_back(edge_n);
      if (reject)     q_rej.push_back(edge_n);
      if (!clear_n)   q_clr.push_back(edge_n);
      if (player_colour !== pc_prev) q_pc.push_back(edge_n);
      pc_prev = player_colour;
      if (sel_column !== change) pair_bad++;
      if (sel_column && (a != 3'd7)) heights[a] = heights[a] + 1;
      if (!clear_n) for (int i = 0; i < 7; i++) heights[i] = 0;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_pulse(input string tag, input int q[$], input int exp_edge);
      check({tag, "_count"}, q.size(), 1);
      if (q.size() > 0) check({tag, "_edge"}, q[0], exp_edge);
   endtask

   task automatic clear_queues();
      q_left.delete(); q_right.delete(); q_sel.delete(); q_chg.delete();
      q_rej.delete();  q_pc.delete();    q_clr.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Raise the chosen buttons right after an edge (j), hold, release, then idle
   task automatic press(input logic l, input logic r, input logic d, input logic n,
                        input int hold, input int idle, output int j);
      clear_queues();
      j = edge_n;
      b_left = l; b_right = r; b_drop = d; b_new = n;
      ticks(hold);
      b_left = 1'b0; b_right = 1'b0; b_drop = 1'b0; b_new = 1'b0;
      ticks(idle);
   endtask

   int   j;
   int   h;
   logic exp_pc;
   logic with_left;
   logic full;

   initial begin
      reset = 1'b0;
      b_left = 1'b0; b_right = 1'b0; b_drop = 1'b0; b_new = 1'b0;
      a = 3'd0; win_drv = 2'b00;
      for (int i = 0; i < 7; i++) heights[i] = 0;
      exp_pc = 1'b0;

      // Reset state and clear_n release
      ticks(3);
      check("rst_status", int'(status), 0);
      check("rst_colour", int'(player_colour), 0);
      check("rst_pulses", int'({left, right, sel_column, change, reject}), 0);
      check("rst_clear_n", int'(clear_n), 0);
      reset = 1'b1;
      #1;
      check("clear_n_before_edge", int'(clear_n), 0);
      tick();
      check("clear_n_after_edge", int'(clear_n), 1);

      // Long drop hold into an empty column
      a = 3'd3;
      press(1'b0, 1'b0, 1'b1, 1'b0, 40, D + 8, j);
      check_pulse("drop_sel", q_sel, j + D + 4);
      check_pulse("drop_chg", q_chg, j + D + 4);
      check_pulse("drop_colour", q_pc, j + D + 4 + S + 1);
      check("drop_no_reject", q_rej.size(), 0);
      check("drop_status", int'(status), 0);
      exp_pc = 1'b1;
      check("drop_colour_val", int'(player_colour), int'(exp_pc));

      // Bounced left: timed from the final rising edge
      clear_queues();
      b_left = 1'b1; ticks(5);
      b_left = 1'b0; ticks(2);
      j = edge_n;
      b_left = 1'b1; ticks(30);
      b_left = 1'b0; ticks(D + 8);
      check_pulse("bounce_left", q_left, j + D + 4);
      check("bounce_no_right", q_right.size(), 0);

      press(1'b0, 1'b1, 1'b0, 1'b0, 25, D + 8, j);
      check_pulse("right", q_right, j + D + 4);
      check("right_no_left", q_left.size(), 0);

      press(1'b1, 1'b1, 1'b0, 1'b0, 25, D + 8, j);
      check("both_no_left", q_left.size(), 0);
      check("both_no_right", q_right.size(), 0);

      // Presses too short to be accepted, then the exact threshold
      press(1'b1, 1'b0, 1'b0, 1'b0, D - 1, D + 8, j);
      check("short_dm1_left", q_left.size(), 0);
      for (int i = 0; i < 3; i++) begin
         h = $urandom_range(1, D - 1);
         press(1'b1, 1'b0, 1'b0, 1'b0, h, D + 8, j);
         check("short_rand_left", q_left.size(), 0);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0, D, D + 8, j);
      check_pulse("threshold_left", q_left, j + D + 4);

      // Drop into a full column
      heights[4] = 6;
      a = 3'd4;
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      check_pulse("full_reject", q_rej, j + D + 4);
      check("full_no_sel", q_sel.size(), 0);
      check("full_no_colour", q_pc.size(), 0);
      check("full_colour_val", int'(player_colour), int'(exp_pc));

      // Random boards, selectors, coincident left and win=11
      for (int it = 0; it < 8; it++) begin
         for (int c = 0; c < 7; c++) heights[c] = $urandom_range(0, 6);
         heights[0] = $urandom_range(0, 4);
         a = 3'($urandom_range(0, 7));
         win_drv = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
         with_left = 1'($urandom_range(0, 1));
         if (a == 3'd7) full = 1'b1;
         else full = (heights[a] == 6);
         press(with_left, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
         if (full) begin
            check_pulse("rand_reject", q_rej, j + D + 4);
            check("rand_no_sel", q_sel.size(), 0);
            check("rand_no_colour", q_pc.size(), 0);
         end else begin
            check_pulse("rand_sel", q_sel, j + D + 4);
            check_pulse("rand_chg", q_chg, j + D + 4);
            check_pulse("rand_colour", q_pc, j + D + 4 + S + 1);
            check("rand_no_reject", q_rej.size(), 0);
            exp_pc = ~exp_pc;
         end
         check("rand_no_left", q_left.size(), 0);
         check("rand_colour_val", int'(player_colour), int'(exp_pc));
         check("rand_status", int'(status), 0);
      end

      // Winning drop, then everything but new-game is ignored
      win_drv = 2'b10;
      for (int c = 0; c < 7; c++) heights[c] = 0;
      a = 3'd2;
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      check_pulse("win_sel", q_sel, j + D + 4);
      check("win_status", int'(status), 1);
      check("win_no_colour", q_pc.size(), 0);
      check("win_colour_val", int'(player_colour), int'(exp_pc));
      press(1'b1, 1'b0, 1'b0, 1'b0, D + 2, D + 8, j);
      check("won_no_left", q_left.size(), 0);
      press(1'b0, 1'b1, 1'b0, 1'b0, D + 2, D + 8, j);
      check("won_no_right", q_right.size(), 0);
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      check("won_no_sel", q_sel.size(), 0);
      check("won_no_reject", q_rej.size(), 0);
      check("won_status_hold", int'(status), 1);

      // New game from WON
      press(1'b0, 1'b0, 1'b0, 1'b1, D + 2, D + 8, j);
      win_drv = 2'b00;
      check("clr_count", q_clr.size(), 2);
      if (q_clr.size() == 2) begin
         check("clr_first", q_clr[0], j + D + 4);
         check("clr_second", q_clr[1], j + D + 5);
      end
      check("new_status", int'(status), 0);
      check("new_colour", int'(player_colour), 0);
      exp_pc = 1'b0;
      a = 3'd2;
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      check_pulse("new_drop_sel", q_sel, j + D + 4);
      exp_pc = 1'b1;
      check("new_drop_colour", int'(player_colour), int'(exp_pc));

      // Draw: the drop fills the last open cell
      for (int c = 0; c < 7; c++) heights[c] = 6;
      heights[0] = 5;
      a = 3'd0;
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      check_pulse("draw_sel", q_sel, j + D + 4);
      check("draw_status", int'(status), 2);
      check("draw_no_colour", q_pc.size(), 0);

      press(1'b0, 1'b0, 1'b0, 1'b1, D + 2, D + 8, j);
      check("draw_clr_count", q_clr.size(), 2);
      check("draw_new_status", int'(status), 0);
      exp_pc = 1'b0;
      a = 3'd1;
      press(1'b0, 1'b0, 1'b1, 1'b0, D + 2, D + 8, j);
      exp_pc = 1'b1;
      check("pre_abort_colour", int'(player_colour), int'(exp_pc));

      // Reset asserted while the next drop is settling
      clear_queues();
      j = edge_n;
      b_drop = 1'b1;
      ticks(D + 4);
      check("abort_sel_high", int'(sel_column), 1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_pulses", int'({left, right, sel_column, change, reject}), 0);
      check("abort_colour", int'(player_colour), 0);
      check("abort_status", int'(status), 0);
      check("abort_clear_n", int'(clear_n), 0);
      b_drop = 1'b0;
      ticks(3);
      reset = 1'b1;
      ticks(D + 8);
      check("abort_colour_after", int'(player_colour), 0);
      check("abort_status_after", int'(status), 0);
      check("abort_clear_n_after", int'(clear_n), 1);

      check("sel_change_paired", pair_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
